// File: rtl/mux_rr_arbiter.sv
// Round-robin 4-way mux arbiter with per-grant burst limit and two-state FSM.
// Latency: one cycle from request in IDLE to registered gnt/sel; re-arbitration on release has no bubble.
// Backpressure: out_ready low freezes gnt, sel and beat_cnt; optional MUX_ARB_LOCK_EN adds a lock input.
module mux_rr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [3:0] sel,
  output logic       out_valid
);

  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    sel_idx;
  logic [1:0]    sel_idx_nxt;
  logic [1:0]    last_idx;
  logic [1:0]    last_idx_nxt;
  logic [3:0]    gnt_nxt;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_cnt_nxt;
  logic [1:0]    base_idx;
  logic [1:0]    win_idx;
  logic          win_vld;
  logic          xfer;
  logic          last_beat;
  logic          cnt_sat;
  logic          hold_lock;
  logic          burst_done;
  logic          release_now;

  // Upper select bits are unused legs of a 4-input mux and stay zero.
  assign sel = {2'b00, sel_idx};

  // Round-robin search: starts one past base and wraps, so base itself is tried last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef MUX_ARB_LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  // While granting, the current owner is the round-robin base; in IDLE the last owner is.
  assign base_idx   = (state == GRANT) ? sel_idx : last_idx;
  assign win_idx    = rr_pick(req, base_idx);
  assign win_vld    = |req;
  assign xfer       = out_valid & out_ready;
  // Compared in 32-bit so BURST_MAX=255 cannot wrap the counter arithmetic.
  assign last_beat  = (32'(beat_cnt) + 1) >= BURST_MAX;
  assign cnt_sat    = 32'(beat_cnt) >= BURST_MAX;
  assign burst_done = xfer & last_beat & ~hold_lock;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant, select, burst counter and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 4'b0000;
      sel_idx  <= 2'd0;
      last_idx <= 2'd3;
      beat_cnt <= '0;
    end else begin
      gnt      <= gnt_nxt;
      sel_idx  <= sel_idx_nxt;
      last_idx <= last_idx_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next-state logic: arbitrate from IDLE, count beats and release/re-arbitrate in GRANT.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    sel_idx_nxt  = sel_idx;
    last_idx_nxt = last_idx;
    beat_cnt_nxt = beat_cnt;
    release_now  = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt    = GRANT;
          gnt_nxt      = 4'b0001 << win_idx;
          sel_idx_nxt  = win_idx;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        // A dropped request never transfers, so it needs no separate xfer qualifier.
        release_now = ~req[sel_idx] | burst_done;
        if (release_now) begin
          last_idx_nxt = sel_idx;
          beat_cnt_nxt = '0;
          if (win_vld) begin
            gnt_nxt     = 4'b0001 << win_idx;
            sel_idx_nxt = win_idx;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end else if (xfer && !cnt_sat) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  // Output logic: a beat is valid only while granting and the owner still requests.
  always_comb begin
    out_valid = (state == GRANT) && req[sel_idx];
  end

endmodule
